// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry valid/ready pipeline register with a skid slot.
// Every output comes straight from a flop, so there is no combinational path
// from in_valid, in_data or out_ready to any output.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   in_valid   upstream word present on in_data
//   in_ready   block can accept a word this cycle (EMPTY or BUSY)
//   in_data    upstream word, N bits
//   flush      synchronous discard of all held words
//   out_valid  out_data holds a word (BUSY or FULL)
//   out_ready  downstream takes out_data this cycle
//   out_data   oldest held word, N bits
//   count      held words: 0, 1 or 2
module pipe_skid_reg #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic [1:0]   count_q, count_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush drops everything but leaves the data registers untouched; an
    // output transfer in the same cycle has already been taken downstream.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    // Output flops are loaded from the next state so they track state_q exactly.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
    unique case (state_d)
      BUSY:    count_d = 2'd1;
      FULL:    count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;

  int unsigned n_checks;
  int unsigned n_pass;

  pipe_skid_reg #(.N(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp_count,
                           input logic exp_ov, input logic exp_ir);
    chk({tag, ".count"},     32'(count),     32'(exp_count));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(exp_ir));
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset for two edges
    step();
    step();
    chk_state("rst", 2'd0, 1'b0, 1'b1);
    chk("rst.out_data", out_data, 32'h0);

    // Single word
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    out_ready = 1'b1;
    step();
    chk_state("single", 2'd1, 1'b1, 1'b1);
    chk("single.out_data", out_data, 32'hDEADBEEF);
    in_valid = 1'b0;
    step();
    chk_state("single.drain", 2'd0, 1'b0, 1'b1);

    // Backpressure fill
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1;
    step();
    chk("fill1.out_data", out_data, 32'h1);
    in_data = 32'h2;
    step();
    chk_state("fill2", 2'd2, 1'b1, 1'b0);
    chk("fill2.out_data", out_data, 32'h1);
    in_data = 32'h3;
    step();
    chk_state("fill3.rejected", 2'd2, 1'b1, 1'b0);
    chk("fill3.out_data", out_data, 32'h1);

    // Drain: 0x1 leaves at next edge, 0x2 shows; 0x3 is retried and accepted
    out_ready = 1'b1;
    step();
    chk_state("drain1", 2'd1, 1'b1, 1'b1);
    chk("drain1.out_data", out_data, 32'h2);
    step();
    chk_state("drain2", 2'd1, 1'b1, 1'b1);
    chk("drain2.out_data", out_data, 32'h3);
    in_valid = 1'b0;
    step();
    chk_state("drain3", 2'd0, 1'b0, 1'b1);

    // Streaming 0x10..0x1F
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'h10 + 32'(i);
      step();
      chk($sformatf("stream%0d.out_data", i), out_data, 32'h10 + 32'(i));
      chk($sformatf("stream%0d.count", i), 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk_state("stream.end", 2'd0, 1'b0, 1'b1);

    // Flush collision from FULL(0xA,0xB) with output transfer and offered 0xC
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data = 32'hB;
    step();
    chk_state("pre_flush", 2'd2, 1'b1, 1'b0);
    chk("pre_flush.out_data", out_data, 32'hA);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'hC;
    step();
    chk_state("flush", 2'd0, 1'b0, 1'b1);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk_state("flush.idle", 2'd0, 1'b0, 1'b1);

    // New word after flush, then an idle cycle in BUSY holds it
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD;
    step();
    chk("post_flush.out_data", out_data, 32'hD);
    in_valid = 1'b0;
    step();
    chk_state("busy_hold", 2'd1, 1'b1, 1'b1);
    chk("busy_hold.out_data", out_data, 32'hD);

    // Reset mid-operation from FULL with input and flush asserted
    in_valid = 1'b1;
    in_data  = 32'hE;
    step();
    chk_state("pre_reset", 2'd2, 1'b1, 1'b0);
    reset    = 1'b0;
    flush    = 1'b1;
    in_data  = 32'hF;
    step();
    chk_state("mid_reset", 2'd0, 1'b0, 1'b1);
    chk("mid_reset.out_data", out_data, 32'h0);
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk_state("post_reset", 2'd0, 1'b0, 1'b1);
    chk("post_reset.out_data", out_data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
